// File: rtl/img_stream_tx_if.sv
// img_stream_tx_if: sensor-side pixel bus (pixel clock, data, frame/line valid).
interface img_stream_tx_if;
  logic        img_dclk;
  logic [11:0] img_d;
  logic        img_fv;
  logic        img_lv;

  modport master (output img_dclk, img_d, img_fv, img_lv);
  modport slave  (input  img_dclk, img_d, img_fv, img_lv);
endinterface

// File: rtl/img_stream_tx.sv
// img_stream_tx: image-sensor emulator. Emits one frame per cmd_frame edge with a
// deterministic pixel ramp; everything on the bus changes on img_dclk falling ticks.
// Optional feature macro: IMG_STREAM_TX_SENSOR_RST_EN adds the img_rst_ sensor reset input.
module img_stream_tx #(
  parameter int unsigned ImgWidth     = 2304,
  parameter int unsigned ImgHeight    = 1296,
  parameter int unsigned HBlankTicks  = 8,
  parameter int unsigned FvLeadTicks  = 4,
  parameter int unsigned FvTrailTicks = 4,
  parameter logic [11:0] PixelInitial = 12'hFFF,
  parameter int          PixelDelta   = -1
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             cmd_frame,
`ifdef IMG_STREAM_TX_SENSOR_RST_EN
  input  logic             img_rst_,
`endif
  output logic             status_frameDone,
  output logic             status_busy,
  img_stream_tx_if.master  img
);

  localparam int unsigned ColW      = $clog2(ImgWidth + 1);
  localparam int unsigned LineW     = $clog2(ImgHeight + 1);
  localparam int unsigned BlankMax0 = (HBlankTicks > FvLeadTicks) ? HBlankTicks : FvLeadTicks;
  localparam int unsigned BlankMax  = (BlankMax0 > FvTrailTicks) ? BlankMax0 : FvTrailTicks;
  localparam int unsigned BlkW      = (BlankMax > 0) ? $clog2(BlankMax + 1) : 1;
  localparam logic [11:0] PixStep   = 12'(PixelDelta);

  typedef enum logic [2:0] {ST_IDLE, ST_LEAD, ST_LINE, ST_HBLANK, ST_TRAIL} state_t;

  state_t           state;
  logic             phase;
  logic             cmd_q;
  logic             cmd_armed;
  logic             cmd_edge;
  logic             pending;
  logic             fv;
  logic             lv;
  logic             done;
  logic             busy;
  logic             srst;
  logic [11:0]      d;
  logic [11:0]      pix;
  logic [ColW-1:0]  col;
  logic [LineW-1:0] line;
  logic [BlkW-1:0]  blk;

`ifdef IMG_STREAM_TX_SENSOR_RST_EN
  assign srst = ~img_rst_;
`else
  assign srst = 1'b0;
`endif

  // Pixel clock: phase toggles every clk; a tick is the edge where it falls.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) phase <= 1'b0;
    else       phase <= ~phase;
  end

  // Command edge detect; armed after the first clk so the reset level is not an edge.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cmd_q     <= 1'b0;
      cmd_armed <= 1'b0;
    end else begin
      cmd_q     <= cmd_frame;
      cmd_armed <= 1'b1;
    end
  end

  assign cmd_edge = cmd_armed && !srst && (cmd_frame != cmd_q);

  // Frame sequencer with registered bus outputs and request latch.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state   <= ST_IDLE;
      pending <= 1'b0;
      fv      <= 1'b0;
      lv      <= 1'b0;
      d       <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      pix     <= '0;
      col     <= '0;
      line    <= '0;
      blk     <= '0;
    end else if (srst) begin
      state   <= ST_IDLE;
      pending <= 1'b0;
      fv      <= 1'b0;
      lv      <= 1'b0;
      d       <= '0;
      busy    <= 1'b0;
    end else begin
      if (phase) begin
        case (state)
          ST_IDLE: begin
            fv <= 1'b0;
            lv <= 1'b0;
            d  <= '0;
            if (pending) begin
              pending <= 1'b0;
              fv      <= 1'b1;
              busy    <= 1'b1;
              line    <= LineW'(ImgHeight - 1);
              if (FvLeadTicks == 0) begin
                state <= ST_LINE;
                lv    <= 1'b1;
                d     <= PixelInitial;
                pix   <= PixelInitial + PixStep;
                col   <= ColW'(ImgWidth - 1);
              end else begin
                state <= ST_LEAD;
                pix   <= PixelInitial;
                blk   <= BlkW'(FvLeadTicks - 1);
              end
            end
          end
          ST_LEAD: begin
            if (blk != '0) begin
              blk <= blk - BlkW'(1);
            end else begin
              state <= ST_LINE;
              lv    <= 1'b1;
              d     <= pix;
              pix   <= pix + PixStep;
              col   <= ColW'(ImgWidth - 1);
            end
          end
          ST_LINE: begin
            if (col != '0) begin
              d   <= pix;
              pix <= pix + PixStep;
              col <= col - ColW'(1);
            end else if (line != '0) begin
              line <= line - LineW'(1);
              if (HBlankTicks == 0) begin
                d   <= pix;
                pix <= pix + PixStep;
                col <= ColW'(ImgWidth - 1);
              end else begin
                state <= ST_HBLANK;
                lv    <= 1'b0;
                d     <= '0;
                blk   <= BlkW'(HBlankTicks - 1);
              end
            end else if (FvTrailTicks == 0) begin
              state <= ST_IDLE;
              fv    <= 1'b0;
              lv    <= 1'b0;
              d     <= '0;
              done  <= ~done;
              busy  <= 1'b0;
            end else begin
              state <= ST_TRAIL;
              lv    <= 1'b0;
              d     <= '0;
              blk   <= BlkW'(FvTrailTicks - 1);
            end
          end
          ST_HBLANK: begin
            if (blk != '0) begin
              blk <= blk - BlkW'(1);
            end else begin
              state <= ST_LINE;
              lv    <= 1'b1;
              d     <= pix;
              pix   <= pix + PixStep;
              col   <= ColW'(ImgWidth - 1);
            end
          end
          ST_TRAIL: begin
            if (blk != '0) begin
              blk <= blk - BlkW'(1);
            end else begin
              state <= ST_IDLE;
              fv    <= 1'b0;
              done  <= ~done;
              busy  <= 1'b0;
            end
          end
          default: begin
            state <= ST_IDLE;
            fv    <= 1'b0;
            lv    <= 1'b0;
            d     <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
      // A new edge on the same clk as service still counts as a fresh request.
      if (cmd_edge) pending <= 1'b1;
    end
  end

  assign img.img_dclk     = phase;
  assign img.img_d        = d;
  assign img.img_fv       = fv;
  assign img.img_lv       = lv;
  assign status_frameDone = done;
  assign status_busy      = busy;

endmodule

// File: tb/tb_img_stream_tx.sv
// tb_img_stream_tx: randomized command timing, scoreboard of expected frames/pixels.
module tb_img_stream_tx;
  localparam int W = 4;
  localparam int H = 3;
  localparam int HB = 2;
  localparam int LEAD = 1;
  localparam int TRAIL = 1;
  localparam int PIX0 = 'hFFF;
  localparam int DELTA = -1;
  localparam int FRAME_TICKS = LEAD + H * W + (H - 1) * HB + TRAIL;
  localparam int W2 = 4;
  localparam int PIX0_2 = 1;

  logic clk = 1'b0;
  logic rst_ = 1'b0;
  logic cmd = 1'b0;
  logic cmd2 = 1'b0;
  logic done, busy, done2, busy2;
`ifdef IMG_STREAM_TX_SENSOR_RST_EN
  logic img_rst_ = 1'b1;
`endif

  img_stream_tx_if bus ();
  img_stream_tx_if bus2 ();

  img_stream_tx #(
    .ImgWidth(W), .ImgHeight(H), .HBlankTicks(HB), .FvLeadTicks(LEAD),
    .FvTrailTicks(TRAIL), .PixelInitial(12'hFFF), .PixelDelta(-1)
  ) dut (
    .clk(clk), .rst_(rst_), .cmd_frame(cmd),
`ifdef IMG_STREAM_TX_SENSOR_RST_EN
    .img_rst_(img_rst_),
`endif
    .status_frameDone(done), .status_busy(busy), .img(bus)
  );

  img_stream_tx #(
    .ImgWidth(W2), .ImgHeight(1), .PixelInitial(12'h001), .PixelDelta(-1)
  ) dut2 (
    .clk(clk), .rst_(rst_), .cmd_frame(cmd2),
`ifdef IMG_STREAM_TX_SENSOR_RST_EN
    .img_rst_(1'b1),
`endif
    .status_frameDone(done2), .status_busy(busy2), .img(bus2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_pix[$];
  logic [11:0] exp_pix2[$];
  int exp_frames[$];
  logic exp_done = 1'b0;
  bit mon_en = 1'b0;

  function automatic void chk(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic logic [11:0] ramp(input int base, input int k);
    int v;
    v = ((base + k * DELTA) % 4096 + 4096) % 4096;
    return 12'(v);
  endfunction

  // Reference model: a request yields W*H ramp pixels; gap is the required fv=0 run before it (-1 = any).
  task automatic push_frame(input int gap);
    for (int k = 0; k < W * H; k++) exp_pix.push_back(ramp(PIX0, k));
    exp_frames.push_back(gap);
    exp_done = ~exp_done;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((exp_frames.size() != 0 || exp_pix.size() != 0 || busy) && g < 500) begin
      @(posedge clk); #1; g++;
    end
    chk("frame_complete_in_time", (g < 500) ? 1 : 0, 1);
    cyc(4);
  endtask

  // Monitor: one sample per tick, on the falling clk after dclk has dropped.
  bit prev_fv, prev_lv, prev_done;
  int fv_len, lv_len, line_cnt, pix_cnt, gap_len;
  always @(negedge clk) begin
    if (!mon_en) begin
      prev_fv = 1'b0; prev_lv = 1'b0; prev_done = done;
      fv_len = 0; lv_len = 0; line_cnt = 0; pix_cnt = 0; gap_len = 100;
    end else if (!bus.img_dclk) begin
      if (bus.img_lv) begin
        chk("lv_inside_fv", bus.img_fv, 1);
        if (exp_pix.size() == 0) chk("pixel_unexpected", 1, 0);
        else chk("pixel", bus.img_d, exp_pix.pop_front());
        lv_len++; pix_cnt++;
      end else begin
        chk("d_zero_when_lv_low", bus.img_d, 0);
        if (prev_lv) begin
          chk("line_width", lv_len, W);
          lv_len = 0; line_cnt++;
        end
      end
      if (bus.img_fv) begin
        chk("busy_in_frame", busy, 1);
        if (!prev_fv) begin
          if (exp_frames.size() == 0) chk("frame_unexpected", 1, 0);
          else begin
            int g;
            g = exp_frames.pop_front();
            if (g >= 0) chk("b2b_gap_ticks", gap_len, g);
          end
          fv_len = 0; line_cnt = 0; pix_cnt = 0;
        end
        fv_len++;
        chk("no_done_toggle_mid_frame", (done != prev_done) ? 1 : 0, 0);
      end else if (prev_fv) begin
        chk("fv_ticks", fv_len, FRAME_TICKS);
        chk("lines_per_frame", line_cnt, H);
        chk("pixels_per_frame", pix_cnt, W * H);
        chk("done_toggles_at_fv_fall", (done != prev_done) ? 1 : 0, 1);
        gap_len = 1;
      end else begin
        gap_len++;
      end
      prev_fv = bus.img_fv; prev_lv = bus.img_lv; prev_done = done;
    end
  end

  always @(negedge clk) begin
    if (rst_ && !bus2.img_dclk && bus2.img_lv) begin
      if (exp_pix2.size() == 0) chk("wrap_pixel_unexpected", 1, 0);
      else chk("wrap_pixel", bus2.img_d, exp_pix2.pop_front());
    end
  end

  initial begin
    int lat, n, g, fvcnt;
    bit toggled;
    cyc(3);
    chk("reset_fv", bus.img_fv, 0);
    chk("reset_lv", bus.img_lv, 0);
    chk("reset_d", bus.img_d, 0);
    chk("reset_dclk", bus.img_dclk, 0);
    chk("reset_done", done, 0);
    chk("reset_busy", busy, 0);
    rst_ = 1'b1;
    mon_en = 1'b1;
    cyc(6);
    chk("no_spurious_start", busy, 0);

    for (int it = 0; it < 8; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        cyc($urandom_range(0, 5));
        cmd = ~cmd;
        push_frame(-1);
        lat = 0;
        while (!bus.img_fv && lat < 10) begin @(posedge clk); #1; lat++; end
        chk("start_latency_2_or_3", (lat >= 2 && lat <= 3) ? 1 : 0, 1);
        wait_idle();
      end else begin
        cmd = ~cmd;
        push_frame(-1);
        cyc($urandom_range(4, 16));
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
          cmd = ~cmd;
          cyc($urandom_range(1, 4));
        end
        push_frame(1);
        wait_idle();
      end
    end
    chk("done_level", done, exp_done);

    // Wrap-around ramp on the second instance.
    cmd2 = ~cmd2;
    for (int k = 0; k < W2; k++) begin
      int v;
      v = ((PIX0_2 - k) % 4096 + 4096) % 4096;
      exp_pix2.push_back(12'(v));
    end
    g = 0;
    while ((exp_pix2.size() != 0 || busy2) && g < 300) begin @(posedge clk); #1; g++; end
    chk("wrap_frame_in_time", (g < 300) ? 1 : 0, 1);
    chk("wrap_done", done2, 1);

    // Asynchronous reset at line 2, pixel 2, with a request pending.
    mon_en = 1'b0;
    cmd = ~cmd;
    n = 0; g = 0; toggled = 1'b0;
    while (n < W + 2 && g < 200) begin
      @(negedge clk); g++;
      if (!bus.img_dclk && bus.img_lv) n++;
      if (n == W && !toggled) begin cmd = ~cmd; toggled = 1'b1; end
    end
    chk("reached_line2_pixel2", n, W + 2);
    rst_ = 1'b0;
    #1;
    chk("arst_fv", bus.img_fv, 0);
    chk("arst_lv", bus.img_lv, 0);
    chk("arst_d", bus.img_d, 0);
    chk("arst_dclk", bus.img_dclk, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    cyc(3);
    rst_ = 1'b1;
    fvcnt = 0;
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (bus.img_fv) fvcnt++; end
    chk("pending_discarded_by_reset", fvcnt, 0);
    exp_pix.delete(); exp_frames.delete(); exp_done = 1'b0;
    mon_en = 1'b1;
    cyc(2);
    cmd = ~cmd;
    push_frame(-1);
    wait_idle();
    chk("done_after_reset_frame", done, exp_done);

`ifdef IMG_STREAM_TX_SENSOR_RST_EN
    // Sensor reset mid-line; command edges during it are ignored.
    mon_en = 1'b0;
    cmd = ~cmd;
    g = 0;
    while (!(bus.img_lv && !bus.img_dclk) && g < 100) begin @(negedge clk); g++; end
    chk("sensor_reached_line", bus.img_lv, 1);
    img_rst_ = 1'b0;
    cyc(2);
    chk("srst_fv", bus.img_fv, 0);
    chk("srst_lv", bus.img_lv, 0);
    chk("srst_d", bus.img_d, 0);
    chk("srst_busy", busy, 0);
    lat = bus.img_dclk;
    cyc(1);
    chk("srst_dclk_runs", (bus.img_dclk != lat[0]) ? 1 : 0, 1);
    cmd = ~cmd;
    cyc(4);
    img_rst_ = 1'b1;
    fvcnt = 0;
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (bus.img_fv) fvcnt++; end
    chk("srst_cmd_ignored", fvcnt, 0);
    chk("srst_no_done_toggle", done, exp_done);
    exp_pix.delete(); exp_frames.delete();
    mon_en = 1'b1;
    cyc(2);
    cmd = ~cmd;
    push_frame(-1);
    wait_idle();
    chk("srst_full_frame_done", done, exp_done);
`endif

    chk("pixels_left", exp_pix.size(), 0);
    chk("frames_left", exp_frames.size(), 0);
    chk("wrap_pixels_left", exp_pix2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
